// File: rtl/game_pkg.sv
// Shared game-level definitions: arbiter state encoding, health width and
// player bit indices used on hit_ack, hit_blocked and ko.
package game_pkg;

  localparam int HEALTH_W = 3;

  localparam int P1 = 0;
  localparam int P2 = 1;

  typedef enum logic [1:0] {
    S_ARB_IDLE   = 2'd0,
    S_ARB_ACTIVE = 2'd1,
    S_ARB_KO     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/stun_timer.sv
// Per-player hit-stun counter: loads on a hit, counts down once per frame,
// and reports active while nonzero.
module stun_timer #(
  parameter int STUN_FRAMES = 30,
  parameter int W           = $clog2(STUN_FRAMES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         active
);

  logic [W-1:0] count;

  // NOTE: clocked state is always written with <= so every register samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign active = (count != '0);

endmodule

// File: rtl/hit_arbiter.sv
// Health owner and per-frame hit arbiter for both players (trade, block, stun).
// Build option: define HIT_ARBITER_CHIP_DAMAGE_EN for 1-point chip damage on blocked hits.
module hit_arbiter
  import game_pkg::*;
#(
  parameter int MAX_HEALTH   = 5,
  parameter int DAMAGE       = 1,
  parameter int STUN_FRAMES  = 30,
  parameter int BLOCK_FRAMES = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fight_active,
  input  logic                p1_hit_req,
  input  logic                p2_hit_req,
  input  logic                p1_block,
  input  logic                p2_block,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_stunned,
  output logic                p2_stunned,
  output logic [1:0]          hit_ack,
  output logic [1:0]          hit_blocked,
  output logic [1:0]          ko
);

  localparam int STUN_W = $clog2(STUN_FRAMES + 1);
  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG_H      = HEALTH_W'(DAMAGE);
  localparam logic [STUN_W-1:0]   STUN_LOAD  = STUN_W'(STUN_FRAMES);
  localparam logic [STUN_W-1:0]   BLOCK_LOAD = STUN_W'(BLOCK_FRAMES);

  arb_state_t state, state_next;
  logic       start_round;
  logic       hits_live;
  logic       p1_accept, p2_accept;

  function automatic logic [HEALTH_W-1:0] hit_health(input logic [HEALTH_W-1:0] h,
                                                     input logic blocked);
    if (!blocked) return (h > DMG_H) ? h - DMG_H : '0;
`ifdef HIT_ARBITER_CHIP_DAMAGE_EN
    return (h > HEALTH_W'(1)) ? h - HEALTH_W'(1) : h;
`else
    return h;
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_ARB_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next  = state;
    start_round = 1'b0;
    hits_live   = 1'b0;
    case (state)
      S_ARB_IDLE: begin
        if (fight_active) begin
          state_next  = S_ARB_ACTIVE;
          start_round = 1'b1;
        end
      end
      S_ARB_ACTIVE: begin
        if (!fight_active) begin
          state_next = S_ARB_IDLE;
        end else begin
          hits_live = 1'b1;
          if (ko != 2'b00) state_next = S_ARB_KO;
        end
      end
      S_ARB_KO: begin
        if (!fight_active) state_next = S_ARB_IDLE;
      end
      default: state_next = S_ARB_IDLE;
    endcase
  end

  // A player's hit lands only when the defender was not stunned before this edge.
  assign p1_accept = hits_live & p1_hit_req & ~p2_stunned;
  assign p2_accept = hits_live & p2_hit_req & ~p1_stunned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_health   <= MAX_H;
      p2_health   <= MAX_H;
      hit_ack     <= 2'b00;
      hit_blocked <= 2'b00;
    end else begin
      hit_ack[P1]     <= p1_accept;
      hit_ack[P2]     <= p2_accept;
      hit_blocked[P1] <= p1_accept & p2_block;
      hit_blocked[P2] <= p2_accept & p1_block;
      if (start_round) begin
        p1_health <= MAX_H;
        p2_health <= MAX_H;
      end else begin
        if (p1_accept) p2_health <= hit_health(p2_health, p2_block);
        if (p2_accept) p1_health <= hit_health(p1_health, p1_block);
      end
    end
  end

  // Each timer guards its own player; it is loaded by the opponent's hit.
  stun_timer #(.STUN_FRAMES(STUN_FRAMES), .W(STUN_W)) u_p1_stun (
    .clk        (clk),
    .reset      (reset),
    .load       (start_round | p2_accept),
    .load_value (start_round ? '0 : (p1_block ? BLOCK_LOAD : STUN_LOAD)),
    .active     (p1_stunned)
  );

  stun_timer #(.STUN_FRAMES(STUN_FRAMES), .W(STUN_W)) u_p2_stun (
    .clk        (clk),
    .reset      (reset),
    .load       (start_round | p1_accept),
    .load_value (start_round ? '0 : (p2_block ? BLOCK_LOAD : STUN_LOAD)),
    .active     (p2_stunned)
  );

  assign ko[P1] = (p1_health == '0);
  assign ko[P2] = (p2_health == '0);

endmodule

// File: tb/tb_hit_arbiter.sv
// Scoreboard bench for hit_arbiter: directed round scenarios plus random frames,
// checked against a frame-level game-rule model.
module tb_hit_arbiter;

  localparam int MAX_HEALTH   = 5;
  localparam int DAMAGE       = 1;
  localparam int STUN_FRAMES  = 30;
  localparam int BLOCK_FRAMES = 10;

  localparam int PH_IDLE  = 0;
  localparam int PH_FIGHT = 1;
  localparam int PH_KO    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       fight_active, p1_hit_req, p2_hit_req, p1_block, p2_block;
  logic [2:0] p1_health, p2_health;
  logic       p1_stunned, p2_stunned;
  logic [1:0] hit_ack, hit_blocked, ko;

  typedef struct {
    int         edge_no;
    logic [1:0] ack;
    logic [1:0] blk;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   edge_cnt   = 0;

  int m_phase, m_h1, m_h2, m_s1, m_s2;

  hit_arbiter #(
    .MAX_HEALTH   (MAX_HEALTH),
    .DAMAGE       (DAMAGE),
    .STUN_FRAMES  (STUN_FRAMES),
    .BLOCK_FRAMES (BLOCK_FRAMES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fight_active (fight_active),
    .p1_hit_req   (p1_hit_req),
    .p2_hit_req   (p2_hit_req),
    .p1_block     (p1_block),
    .p2_block     (p2_block),
    .p1_health    (p1_health),
    .p2_health    (p2_health),
    .p1_stunned   (p1_stunned),
    .p2_stunned   (p2_stunned),
    .hit_ack      (hit_ack),
    .hit_blocked  (hit_blocked),
    .ko           (ko)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int after_hit(input int h, input logic blocked);
    if (!blocked) return (h > DAMAGE) ? h - DAMAGE : 0;
`ifdef HIT_ARBITER_CHIP_DAMAGE_EN
    return (h > 1) ? h - 1 : h;
`else
    return h;
`endif
  endfunction

  function automatic int tick(input int s);
    return (s > 0) ? s - 1 : 0;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_h1 = MAX_HEALTH;
    m_h2 = MAX_HEALTH;
    m_s1 = 0;
    m_s2 = 0;
    q.delete();
  endtask

  // One frame of game rules, applied to the pre-edge model state.
  task automatic model_step(input logic fa, input logic r1, input logic r2,
                            input logic b1, input logic b2);
    logic a1, a2;
    int   n_h1, n_h2, n_s1, n_s2, n_phase;
    a1 = 1'b0;
    a2 = 1'b0;
    n_h1 = m_h1;
    n_h2 = m_h2;
    n_s1 = tick(m_s1);
    n_s2 = tick(m_s2);
    n_phase = m_phase;
    if (m_phase == PH_IDLE) begin
      if (fa) begin
        n_phase = PH_FIGHT;
        n_h1 = MAX_HEALTH;
        n_h2 = MAX_HEALTH;
        n_s1 = 0;
        n_s2 = 0;
      end
    end else if (!fa) begin
      n_phase = PH_IDLE;
    end else if (m_phase == PH_FIGHT) begin
      a1 = r1 && (m_s2 == 0);
      a2 = r2 && (m_s1 == 0);
      if (a1) begin
        n_h2 = after_hit(m_h2, b2);
        n_s2 = b2 ? BLOCK_FRAMES : STUN_FRAMES;
      end
      if (a2) begin
        n_h1 = after_hit(m_h1, b1);
        n_s1 = b1 ? BLOCK_FRAMES : STUN_FRAMES;
      end
      if (m_h1 == 0 || m_h2 == 0) n_phase = PH_KO;
    end
    if (a1 || a2) q.push_back('{edge_cnt + 1, {a2, a1}, {a2 && b1, a1 && b2}});
    m_phase = n_phase;
    m_h1 = n_h1;
    m_h2 = n_h2;
    m_s1 = n_s1;
    m_s2 = n_s2;
  endtask

  task automatic check_frame();
    check("health", {p1_health, p2_health}, {3'(m_h1), 3'(m_h2)});
    check("stunned", {p2_stunned, p1_stunned}, {m_s2 != 0, m_s1 != 0});
    check("ko", ko, {m_h2 == 0, m_h1 == 0});
  endtask

  // Called at a negedge; inputs held until the following negedge.
  task automatic step(input logic fa, input logic r1, input logic r2,
                      input logic b1, input logic b2);
    fight_active = fa;
    p1_hit_req   = r1;
    p2_hit_req   = r2;
    p1_block     = b1;
    p2_block     = b2;
    model_step(fa, r1, r2, b1, b2);
    @(posedge clk);
    @(negedge clk);
    check_frame();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart_round();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every ack the DUT presents must match the oldest expected ack.
  always @(negedge clk) begin
    if (!reset && (hit_ack != 2'b00 || hit_blocked != 2'b00)) begin
      if (q.size() == 0) begin
        check("unexpected_ack", {hit_blocked, hit_ack}, 4'b0000);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ack_edge", edge_cnt, e.edge_no);
        check("hit_ack", hit_ack, e.ack);
        check("hit_blocked", hit_blocked, e.blk);
      end
    end
  end

  initial begin
    reset = 1'b1;
    fight_active = 1'b0;
    p1_hit_req = 1'b0;
    p2_hit_req = 1'b0;
    p1_block = 1'b0;
    p2_block = 1'b0;
    model_reset();
    #3;
    check_frame();
    check("reset_ack", {hit_blocked, hit_ack}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Round start, then a held attack landing once per stun window.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(31);

    // Trade, then a blocked hit followed by a held attack after block stun.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    quiet(31);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(31);

    // Block at defender health 1.
    restart_round();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      quiet(30);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet(10);

    // Trades down to double KO, requests in KO, then back to idle.
    restart_round();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      quiet(30);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stun at health 2/3.
    restart_round();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      quiet(30);
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_pending", q.size(), 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_frame();
    check("mid_reset_ack", {hit_blocked, hit_ack}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Random frames with occasional fight_active drops to restart rounds.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pending_acks", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
